// File: rtl/apb_wait_completer_pkg.sv
// Shared types, constants and helpers for the APB wait-state completer.
package apb_wait_completer_pkg;

  localparam int unsigned APB_ADDR_W   = 32'd8;
  localparam int unsigned APB_DATA_W   = 32'd8;
  // Largest wait-state count the 4-bit wait counter can hold.
  localparam int unsigned APB_WAIT_MAX = 32'd15;

  // Transfer sequencing: IDLE waits for a setup phase, ACCESS runs the wait
  // states and the completing cycle, DONE is the cycle after pready.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

  // True when addr falls inside the implemented register window.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned num_regs);
    return (addr < num_regs);
  endfunction

endpackage

// File: rtl/apb_wait_completer_if.sv
// APB3 bus bundle between a requester (master) and the completer (slave).
interface apb_wait_completer_if
  import apb_wait_completer_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_wait_completer_reg_bank.sv
// Register bank behind the APB completer: storage, write commit, one-cycle
// write strobes and the combinational read mux used by the bus front end.
module apb_wait_completer_reg_bank
  import apb_wait_completer_pkg::*;
#(
  parameter int unsigned ADDR_W   = APB_ADDR_W,
  parameter int unsigned DATA_W   = APB_DATA_W,
  parameter int unsigned NUM_REGS = 32'd8
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [ADDR_W-1:0]            raddr_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [NUM_REGS-1:0] wr_hit_s;
  logic [DATA_W-1:0]   rdata_s;

  // One-hot decode of the register targeted by a committing write.
  always_comb begin
    wr_hit_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we_i && (waddr_i == ADDR_W'(i))) begin
        wr_hit_s[i] = 1'b1;
      end else begin
        wr_hit_s[i] = 1'b0;
      end
    end
  end

  // Register storage and the strobe that marks the cycle after a write.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      wr_pulse_q <= {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit_s[i]) begin
          regs_q[i] <= wdata_i;
        end else begin
          regs_q[i] <= regs_q[i];
        end
      end
      wr_pulse_q <= wr_hit_s;
    end
  end

  // Read mux; addresses outside the bank read as zero.
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rdata_s = (raddr_i == ADDR_W'(i)) ? regs_q[i] : rdata_s;
    end
  end

  // Flatten the bank so register i sits at [i*DATA_W +: DATA_W].
  always_comb begin
    regs_o = {(NUM_REGS*DATA_W){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign rdata_o    = rdata_s;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/apb_wait_completer.sv
// APB3 completer front end: decodes setup/access phases, inserts a fixed
// number of wait states, answers from a small register bank, flags
// out-of-range addresses with pslverr and latches protocol violations.
module apb_wait_completer
  import apb_wait_completer_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned NUM_REGS    = 32'd8,
  parameter int unsigned WAIT_CYCLES = 32'd0
) (
  input  logic                       pclk,
  input  logic                       preset,
  apb_wait_completer_if.slave        apb,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse,
  output logic                       proto_err
);

  // Wait count loaded at each setup phase, clamped to the counter range.
  localparam logic [3:0] WAIT_LD = (WAIT_CYCLES > APB_WAIT_MAX) ? 4'(APB_WAIT_MAX)
                                                                 : 4'(WAIT_CYCLES);

  apb_state_e        state_q,    state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              wr_q,       wr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              pready_q,   pready_d;
  logic              pslverr_q,  pslverr_d;
  logic [DATA_W-1:0] prdata_q,   prdata_d;
  logic              proto_q,    proto_d;

  logic              setup_s;
  logic              viol_s;
  logic              commit_s;
  logic              next_ok_s;
  logic [DATA_W-1:0] rdata_s;

  // Bus qualifiers: a setup phase, and a write that commits this cycle.
  always_comb begin
    setup_s  = apb.psel & ~apb.penable;
    commit_s = apb.psel & apb.penable & pready_q & wr_q & in_range(32'(addr_q), NUM_REGS);
  end

  // Protocol-violation detection for the current bus cycle.
  always_comb begin
    viol_s = ~apb.psel & apb.penable;
    case (state_q)
      IDLE:    viol_s = viol_s | apb.penable;
      ACCESS:  viol_s = viol_s | ~apb.psel | ~apb.penable
                        | (apb.paddr  != addr_q)
                        | (apb.pwrite != wr_q)
                        | (apb.pwdata != wdata_q);
      DONE:    viol_s = viol_s;
      default: viol_s = 1'b1;
    endcase
  end

  // Next-state, wait counter and transfer latches. pready is computed one
  // cycle early so it is registered yet lands in the intended access cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    pready_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (setup_s) begin
          state_d    = ACCESS;
          wait_cnt_d = WAIT_LD;
          addr_d     = apb.paddr;
          wr_d       = apb.pwrite;
          wdata_d    = apb.pwdata;
          pready_d   = (WAIT_LD == 4'd0);
        end else begin
          state_d    = IDLE;
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          // Requester walked away: abandon without completing.
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == 4'd0) begin
          // This is the pready cycle; the transfer is finished.
          state_d    = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          pready_d   = (wait_cnt_q == 4'd1);
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Response data for the upcoming pready cycle, zero otherwise.
  always_comb begin
    next_ok_s = in_range(32'(addr_d), NUM_REGS);
    pslverr_d = pready_d & ~next_ok_s;
    if (pready_d && !wr_d && next_ok_s) begin
      prdata_d = rdata_s;
    end else begin
      prdata_d = {DATA_W{1'b0}};
    end
    proto_d = proto_q | viol_s;
  end

  // Transfer FSM with registered bus responses and sticky error flag.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= {ADDR_W{1'b0}};
      wr_q       <= 1'b0;
      wdata_q    <= {DATA_W{1'b0}};
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= {DATA_W{1'b0}};
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      proto_q    <= proto_d;
    end
  end

  apb_wait_completer_reg_bank #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_bank (
    .pclk       (pclk),
    .preset     (preset),
    .we_i       (commit_s),
    .waddr_i    (addr_q),
    .wdata_i    (wdata_q),
    .raddr_i    (addr_d),
    .rdata_o    (rdata_s),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse)
  );

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;
  assign proto_err   = proto_q;

endmodule
